// File: rtl/sdp_req_sequencer.sv
// sdp_req_sequencer: request front end for one simple-dual-port block-RAM
// channel. Registers the memory write and read ports and tracks the one-cycle
// registered read latency. Read data returns through a credit-limited
// response FIFO. A read that collides with a same-cycle write to the same
// address is held for one cycle, so it observes the newly written data.
module sdp_req_sequencer #(
   parameter int WABITS     = 10,
   parameter int WDBITS     = 36,
   parameter int BYTEWIDTH  = 9,
   parameter int NBYTES     = WDBITS / BYTEWIDTH,
   parameter int RESP_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   // write request
   input  logic              wreq_valid,
   output logic              wreq_ready,
   input  logic [WABITS-1:0] wreq_addr,
   input  logic [WDBITS-1:0] wreq_data,
   input  logic [NBYTES-1:0] wreq_be,
   // read request
   input  logic              rreq_valid,
   output logic              rreq_ready,
   input  logic [WABITS-1:0] rreq_addr,
   // read response
   output logic              rresp_valid,
   input  logic              rresp_ready,
   output logic [WDBITS-1:0] rresp_data,
   // memory write port
   output logic [WABITS-1:0] wa,
   output logic [WDBITS-1:0] wd,
   output logic              we,
   output logic [NBYTES-1:0] be,
   // memory read port
   output logic [WABITS-1:0] ra,
   output logic              re,
   input  logic [WDBITS-1:0] rd
);

   localparam int CW = $clog2(RESP_DEPTH + 1);
   localparam int PW = $clog2(RESP_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(RESP_DEPTH - 1);

   // memory port registers
   logic [WABITS-1:0] wa_q, ra_q;
   logic [WDBITS-1:0] wd_q;
   logic [NBYTES-1:0] be_q;
   logic              we_q, re_q;
   // data-stage valid: rd carries the result of the read issued last cycle
   logic              cap_q;
   // read credits in use and response FIFO state
   logic [CW-1:0]     outst_q, outst_d;
   logic [CW-1:0]     fcnt_q, fcnt_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WDBITS-1:0] fifo_q [RESP_DEPTH];

   logic hazard, wr_issue, rd_acc, push, pop;

   // A same-address write wins the cycle; the read retries next cycle.
   assign hazard     = wreq_valid && (wreq_be != '0) && rreq_valid && (wreq_addr == rreq_addr);
   assign wreq_ready = !rst;
   assign rreq_ready = !rst && (outst_q < DEPTH_C) && !hazard;
   assign wr_issue   = wreq_valid && wreq_ready && (wreq_be != '0);
   assign rd_acc     = rreq_valid && rreq_ready;
   assign push       = cap_q;
   assign rresp_valid = (fcnt_q != '0);
   assign pop        = rresp_valid && rresp_ready;
   assign rresp_data = rresp_valid ? fifo_q[rd_ptr_q] : '0;

   assign wa = wa_q;
   assign wd = wd_q;
   assign we = we_q;
   assign be = be_q;
   assign ra = ra_q;
   assign re = re_q;

   // Next-state for credit counter, FIFO occupancy and FIFO pointers.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      outst_d  = outst_q;
      fcnt_d   = fcnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      case ({rd_acc, pop})
         2'b10:   outst_d = outst_q + CW'(1);
         2'b01:   outst_d = outst_q - CW'(1);
         default: outst_d = outst_q;
      endcase
      case ({push, pop})
         2'b10:   fcnt_d = fcnt_q + CW'(1);
         2'b01:   fcnt_d = fcnt_q - CW'(1);
         default: fcnt_d = fcnt_q;
      endcase
      if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
   end

   // Memory port registers, read-latency tracking and FIFO control state.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         wa_q     <= '0;
         wd_q     <= '0;
         be_q     <= '0;
         we_q     <= 1'b0;
         ra_q     <= '0;
         re_q     <= 1'b0;
         cap_q    <= 1'b0;
         outst_q  <= '0;
         fcnt_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         we_q <= wr_issue;
         if (wr_issue) begin
            wa_q <= wreq_addr;
            wd_q <= wreq_data;
            be_q <= wreq_be;
         end
         re_q <= rd_acc;
         if (rd_acc) ra_q <= rreq_addr;
         cap_q    <= re_q;
         outst_q  <= outst_d;
         fcnt_q   <= fcnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Response FIFO storage; captures rd whenever the data stage is valid.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; occupancy (fcnt_q) is reset and
      // rresp_data is forced to zero while the FIFO is empty.
      if (push) fifo_q[wr_ptr_q] <= rd;
   end

endmodule

// File: tb/tb_sdp_req_sequencer.sv
// Directed testbench for sdp_req_sequencer with a behavioural byte-enabled
// SDP block-RAM (registered read) attached to the memory ports.
module tb_sdp_req_sequencer;

   localparam int WA = 10;
   localparam int WD = 36;
   localparam int NB = 4;
   localparam int BW = 9;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wreq_valid, wreq_ready;
   logic [WA-1:0] wreq_addr;
   logic [WD-1:0] wreq_data;
   logic [NB-1:0] wreq_be;
   logic          rreq_valid, rreq_ready;
   logic [WA-1:0] rreq_addr;
   logic          rresp_valid, rresp_ready;
   logic [WD-1:0] rresp_data;
   logic [WA-1:0] wa, ra;
   logic [WD-1:0] wd;
   logic          we, re;
   logic [NB-1:0] be;
   logic [WD-1:0] rd;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sdp_req_sequencer #(
      .WABITS(WA), .WDBITS(WD), .BYTEWIDTH(BW), .NBYTES(NB), .RESP_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .wreq_valid(wreq_valid), .wreq_ready(wreq_ready), .wreq_addr(wreq_addr),
      .wreq_data(wreq_data), .wreq_be(wreq_be),
      .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .rreq_addr(rreq_addr),
      .rresp_valid(rresp_valid), .rresp_ready(rresp_ready), .rresp_data(rresp_data),
      .wa(wa), .wd(wd), .we(we), .be(be), .ra(ra), .re(re), .rd(rd)
   );

   // Behavioural SDP RAM: byte-enabled write, one-cycle registered read.
   logic [WD-1:0] mem [1 << WA];
   initial begin
      for (int i = 0; i < (1 << WA); i++) mem[i] = '0;
      rd = '0;
   end
   always @(posedge clk) begin
      if (we)
         for (int l = 0; l < NB; l++)
            if (be[l]) mem[wa][l*BW +: BW] <= wd[l*BW +: BW];
      if (re) rd <= mem[ra];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; registered outputs are then stable.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs follow freshly driven inputs.
   task automatic settle();
      #1;
   endtask

   task automatic do_write(input logic [WA-1:0] addr, input logic [WD-1:0] data,
                           input logic [NB-1:0] bev);
      wreq_valid = 1'b1; wreq_addr = addr; wreq_data = data; wreq_be = bev;
      step();
      wreq_valid = 1'b0; wreq_be = '0;
   endtask

   // Issue one read and check the response appears exactly 2 edges later.
   task automatic read_expect(input string tag, input logic [WA-1:0] addr,
                              input logic [WD-1:0] exp);
      rreq_valid = 1'b1; rreq_addr = addr;
      settle();
      check({tag, "_ready"}, rreq_ready, 1);
      step();
      rreq_valid = 1'b0;
      check({tag, "_re"}, re, 1);
      check({tag, "_ra"}, ra, addr);
      step();
      check({tag, "_early"}, rresp_valid, 0);
      step();
      check({tag, "_valid"}, rresp_valid, 1);
      check({tag, "_data"}, rresp_data, exp);
      rresp_ready = 1'b1;
      step();
      rresp_ready = 1'b0;
      check({tag, "_empty"}, rresp_valid, 0);
   endtask

   // Overall time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      int n_acc, n_pop, first_acc, last_acc;
      rst = 1'b1; wreq_valid = 0; wreq_addr = '0; wreq_data = '0; wreq_be = '0;
      rreq_valid = 0; rreq_addr = '0; rresp_ready = 0;

      // ---- reset state ----
      step(); step();
      check("rst_wready", wreq_ready, 0);
      check("rst_rready", rreq_ready, 0);
      check("rst_we", we, 0);
      check("rst_re", re, 0);
      check("rst_wa", wa, 0);
      check("rst_wd", wd, 0);
      check("rst_be", be, 0);
      check("rst_ra", ra, 0);
      check("rst_rvalid", rresp_valid, 0);
      check("rst_rdata", rresp_data, 0);
      rst = 1'b0;
      settle();
      check("post_rst_wready", wreq_ready, 1);
      check("post_rst_rready", rreq_ready, 1);

      // ---- full write then read ----
      do_write(10'h005, 36'h123456789, 4'hF);
      check("w1_we", we, 1);
      check("w1_be", be, 4'hF);
      check("w1_wa", wa, 10'h005);
      check("w1_wd", wd, 36'h123456789);
      read_expect("r1", 10'h005, 36'h123456789);
      check("w1_we_drop", we, 0);

      // ---- partial write: lane 1 is bits 17:9 ----
      do_write(10'h000, 36'h111111111, 4'hF);
      do_write(10'h000, 36'h0000AB000, 4'h2);
      read_expect("partial", 10'h000, 36'h11112B111);

      // ---- same-cycle same-address collision ----
      wreq_valid = 1'b1; wreq_addr = 10'h010; wreq_data = 36'h0A5; wreq_be = 4'hF;
      rreq_valid = 1'b1; rreq_addr = 10'h010;
      settle();
      check("haz_rready", rreq_ready, 0);
      check("haz_wready", wreq_ready, 1);
      step();
      wreq_valid = 1'b0; wreq_be = '0;
      check("haz_re_held", re, 0);
      read_expect("haz", 10'h010, 36'h0000000A5);

      // ---- credit stall: 8 reads, responses blocked ----
      for (int i = 0; i < 8; i++) do_write(WA'(32 + i), WD'(256 + i), 4'hF);
      for (int c = 0; c < 8; c++) begin
         rreq_valid = 1'b1; rreq_addr = WA'(32 + ((c < 4) ? c : 4));
         settle();
         check($sformatf("stall_ready_%0d", c), rreq_ready, (c < 4));
         step();
      end
      check("stall_rvalid", rresp_valid, 1);
      check("stall_head", rresp_data, 36'h100);
      rresp_ready = 1'b1;
      n_acc = 4; n_pop = 0; first_acc = -1; last_acc = -1;
      for (int c = 0; c < 40 && n_pop < 8; c++) begin
         rreq_valid = (n_acc < 8); rreq_addr = WA'(32 + n_acc);
         settle();
         if (rresp_valid && rresp_ready) begin
            check($sformatf("order_%0d", n_pop), rresp_data, WD'(256 + n_pop));
            n_pop++;
         end
         if (rreq_valid && rreq_ready) begin
            if (first_acc < 0) first_acc = c;
            last_acc = c;
            n_acc++;
         end
         step();
      end
      rreq_valid = 1'b0; rresp_ready = 1'b0;
      check("stall_pops", n_pop, 8);
      check("stall_accepts", n_acc, 8);
      check("reenable_cycle", first_acc, 1);
      check("accept_rate", last_acc - first_acc, 3);

      // ---- reset with 3 reads outstanding ----
      for (int i = 0; i < 3; i++) begin
         rreq_valid = 1'b1; rreq_addr = WA'(32 + i);
         step();
      end
      rreq_valid = 1'b0;
      rst = 1'b1;
      settle();
      check("mid_rst_wready", wreq_ready, 0);
      check("mid_rst_rready", rreq_ready, 0);
      step();
      rst = 1'b0;
      settle();
      check("mid_rst_rvalid", rresp_valid, 0);
      check("mid_rst_rdata", rresp_data, 0);
      check("mid_rst_we", we, 0);
      check("mid_rst_re", re, 0);
      for (int c = 0; c < 4; c++) begin
         step();
         check($sformatf("no_stale_%0d", c), rresp_valid, 0);
      end
      // all credits must be free again: exactly 4 accepted
      for (int c = 0; c < 5; c++) begin
         rreq_valid = 1'b1; rreq_addr = WA'(36 + ((c < 4) ? c : 3));
         settle();
         check($sformatf("credit_ready_%0d", c), rreq_ready, (c < 4));
         step();
      end
      rreq_valid = 1'b0;
      rresp_ready = 1'b1;
      n_pop = 0;
      for (int c = 0; c < 20 && n_pop < 4; c++) begin
         settle();
         if (rresp_valid) begin
            check($sformatf("post_rst_order_%0d", n_pop), rresp_data, WD'(260 + n_pop));
            n_pop++;
         end
         step();
      end
      rresp_ready = 1'b0;
      check("post_rst_pops", n_pop, 4);
      check("post_rst_drained", rresp_valid, 0);

      // ---- be=0 write does not block a same-address read ----
      do_write(10'h003, 36'h1FF, 4'hF);
      wreq_valid = 1'b1; wreq_addr = 10'h003; wreq_data = 36'hFFFFFFFFF; wreq_be = 4'h0;
      rreq_valid = 1'b1; rreq_addr = 10'h003;
      settle();
      check("be0_rready", rreq_ready, 1);
      step();
      wreq_valid = 1'b0; rreq_valid = 1'b0;
      check("be0_we", we, 0);
      check("be0_re", re, 1);
      step();
      check("be0_we_later", we, 0);
      step();
      check("be0_rvalid", rresp_valid, 1);
      check("be0_rdata", rresp_data, 36'h1FF);
      rresp_ready = 1'b1;
      step();
      rresp_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
